// File: rtl/operator_sequencer.sv
// Operator sequencer: sweeps voice-operator IDs once per frame, then opens a
// short gap in which queued configuration commands are committed.
module operator_sequencer #(
  parameter int NUM_VOICE_OPERATORS = 256,
  parameter int GAP_CYCLES          = 8,
  parameter int CMD_FIFO_DEPTH      = 4
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_Enable,
  input  logic        i_CmdValid,
  output logic        o_CmdReady,
  input  logic [1:0]  i_CmdType,
  input  logic [7:0]  i_CmdAddr,
  input  logic [15:0] i_CmdData,
  output logic [7:0]  o_VoiceOperator,
  output logic        o_OperatorValid,
  output logic        o_FrameStart,
  output logic        o_FrameDone,
  output logic        o_PhaseStepConfigWriteEnable,
  output logic [1:0]  o_NoteOnConfigWriteEnable,
  output logic [7:0]  o_ConfigWriteAddr,
  output logic [15:0] o_ConfigWriteData
);

  localparam int OP_W  = $clog2(NUM_VOICE_OPERATORS);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int PTR_W = (CMD_FIFO_DEPTH > 1) ? $clog2(CMD_FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(CMD_FIFO_DEPTH + 1);

  localparam logic [OP_W-1:0]  LAST_OP  = OP_W'(NUM_VOICE_OPERATORS - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(CMD_FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CMD_FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  typedef struct packed {
    logic [1:0]  ctype;
    logic [7:0]  addr;
    logic [15:0] data;
  } cmd_t;

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              valid_q, valid_d;
  logic              fstart_q, fstart_d;
  logic              fdone_q, fdone_d;

  cmd_t              mem_q [CMD_FIFO_DEPTH];
  cmd_t              mem_d [CMD_FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d;
  logic [PTR_W-1:0]  rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;

  logic              ps_we_q, ps_we_d;
  logic [1:0]        note_we_q, note_we_d;
  logic [7:0]        waddr_q, waddr_d;
  logic [15:0]       wdata_q, wdata_d;

  logic              push_s;
  logic              pop_s;
  cmd_t              head_s;

  // Frame FSM: IDLE -> SWEEP (one ID per cycle) -> GAP (fixed length) -> SWEEP/IDLE
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    gap_d    = gap_q;
    valid_d  = 1'b0;
    fstart_d = 1'b0;
    fdone_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_Enable) begin
          state_d  = ST_SWEEP;
          op_d     = {OP_W{1'b0}};
          valid_d  = 1'b1;
          fstart_d = 1'b1;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_SWEEP: begin
        // Enable is not sampled here, so a started sweep always runs to the end.
        if (op_q == LAST_OP) begin
          state_d = ST_GAP;
          gap_d   = {GAP_W{1'b0}};
          fdone_d = 1'b1;
        end else begin
          op_d    = op_q + OP_W'(1);
          valid_d = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == LAST_GAP) begin
          if (i_Enable) begin
            state_d  = ST_SWEEP;
            op_d     = {OP_W{1'b0}};
            valid_d  = 1'b1;
            fstart_d = 1'b1;
          end else begin
            state_d  = ST_IDLE;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Command FIFO bookkeeping and the config write strobes produced by a pop
  always_comb begin
    push_s    = i_CmdValid & ready_q;
    pop_s     = (state_q == ST_GAP) && (cnt_q != {CNT_W{1'b0}});
    head_s    = mem_q[rd_q];
    mem_d     = mem_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    ps_we_d   = 1'b0;
    note_we_d = 2'b00;
    waddr_d   = 8'h00;
    wdata_d   = 16'h0000;

    if (push_s) begin
      mem_d[wr_q] = '{ctype: i_CmdType, addr: i_CmdAddr, data: i_CmdData};
      wr_d        = (wr_q == LAST_PTR) ? {PTR_W{1'b0}} : wr_q + PTR_W'(1);
    end else begin
      wr_d = wr_q;
    end

    if (pop_s) begin
      rd_d = (rd_q == LAST_PTR) ? {PTR_W{1'b0}} : rd_q + PTR_W'(1);
      case (head_s.ctype)
        2'd0: begin
          ps_we_d = 1'b1;
          waddr_d = head_s.addr;
          wdata_d = head_s.data;
        end
        2'd1: begin
          note_we_d = 2'b01;
          wdata_d   = head_s.data;
        end
        2'd2: begin
          note_we_d = 2'b10;
          wdata_d   = head_s.data;
        end
        default: begin
          note_we_d = 2'b00;
        end
      endcase
    end else begin
      rd_d = rd_q;
    end

    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    // Ready follows the committed count only; a pop frees a slot one cycle later.
    ready_d = (cnt_d != FULL_CNT);
  end

  // State, FIFO and output registers
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q   <= ST_IDLE;
      op_q      <= {OP_W{1'b0}};
      gap_q     <= {GAP_W{1'b0}};
      valid_q   <= 1'b0;
      fstart_q  <= 1'b0;
      fdone_q   <= 1'b0;
      for (int i = 0; i < CMD_FIFO_DEPTH; i++) begin
        mem_q[i] <= '{ctype: 2'd0, addr: 8'h00, data: 16'h0000};
      end
      wr_q      <= {PTR_W{1'b0}};
      rd_q      <= {PTR_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      ready_q   <= 1'b0;
      ps_we_q   <= 1'b0;
      note_we_q <= 2'b00;
      waddr_q   <= 8'h00;
      wdata_q   <= 16'h0000;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      gap_q     <= gap_d;
      valid_q   <= valid_d;
      fstart_q  <= fstart_d;
      fdone_q   <= fdone_d;
      mem_q     <= mem_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      ps_we_q   <= ps_we_d;
      note_we_q <= note_we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign o_CmdReady                   = ready_q;
  assign o_VoiceOperator              = 8'(op_q) & {8{valid_q}};
  assign o_OperatorValid              = valid_q;
  assign o_FrameStart                 = fstart_q;
  assign o_FrameDone                  = fdone_q;
  assign o_PhaseStepConfigWriteEnable = ps_we_q;
  assign o_NoteOnConfigWriteEnable    = note_we_q;
  assign o_ConfigWriteAddr            = waddr_q;
  assign o_ConfigWriteData            = wdata_q;

endmodule

// File: tb/tb_operator_sequencer.sv
// Scoreboard bench for operator_sequencer: frame timing, command commit order,
// back-pressure, enable drop mid-sweep, type-3 discard and mid-frame reset.
module tb_operator_sequencer;

  localparam int N   = 256;
  localparam int GAP = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_type;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic [7:0]  voice_op;
  logic        op_valid;
  logic        frame_start;
  logic        frame_done;
  logic        ps_we;
  logic [1:0]  note_we;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [26:0] sb_q[$];
  int          strobe_count = 0;
  int          exp_id       = 0;
  int          last_start   = 0;
  int          last_done    = 0;
  bit          have_start   = 1'b0;
  bit          have_done    = 1'b0;

  logic [38:0] outs_s;
  assign outs_s = {cmd_ready, voice_op, op_valid, frame_start, frame_done,
                   ps_we, note_we, wr_addr, wr_data};

  operator_sequencer #(
    .NUM_VOICE_OPERATORS(N),
    .GAP_CYCLES(GAP),
    .CMD_FIFO_DEPTH(4)
  ) dut (
    .i_Clock(clk),
    .i_Reset_n(rst_n),
    .i_Enable(enable),
    .i_CmdValid(cmd_valid),
    .o_CmdReady(cmd_ready),
    .i_CmdType(cmd_type),
    .i_CmdAddr(cmd_addr),
    .i_CmdData(cmd_data),
    .o_VoiceOperator(voice_op),
    .o_OperatorValid(op_valid),
    .o_FrameStart(frame_start),
    .o_FrameDone(frame_done),
    .o_PhaseStepConfigWriteEnable(ps_we),
    .o_NoteOnConfigWriteEnable(note_we),
    .o_ConfigWriteAddr(wr_addr),
    .o_ConfigWriteData(wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [26:0] exp_pack(input logic [1:0] t, input logic [7:0] a,
                                           input logic [15:0] d);
    logic [1:0] nw;
    nw = (t == 2'd1) ? 2'b01 : ((t == 2'd2) ? 2'b10 : 2'b00);
    return {(t == 2'd0), nw, ((t == 2'd0) ? a : 8'h00), d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] t, input logic [7:0] a, input logic [15:0] d,
                      output int acc_cyc, output int waited);
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_addr  = a;
    cmd_data  = d;
    waited    = 0;
    while (!cmd_ready && waited < 600) begin
      tick();
      waited++;
    end
    chk("push_timeout", 64'(cmd_ready), 64'd1);
    acc_cyc = cyc;
    if (cmd_ready && t != 2'd3) sb_q.push_back(exp_pack(t, a, d));
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_start(output int c);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_start && n < 2000);
    chk("wait_start_timeout", 64'(frame_start), 64'd1);
    c = cyc;
  endtask

  task automatic wait_done(output int c);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_done && n < 2000);
    chk("wait_done_timeout", 64'(frame_done), 64'd1);
    c = cyc;
  endtask

  task automatic wait_id(input int id);
    int n;
    n = 0;
    while (!(op_valid && voice_op == 8'(id)) && n < 2000) begin
      tick();
      n++;
    end
    chk("wait_id_timeout", 64'(op_valid && voice_op == 8'(id)), 64'd1);
  endtask

  // Output monitor: ID sequence, frame pulses, strobe window and scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_id     = 0;
      have_start = 1'b0;
      have_done  = 1'b0;
    end else begin
      if (frame_start) begin
        chk("fs_valid", 64'(op_valid), 64'd1);
        chk("fs_id", 64'(voice_op), 64'd0);
        last_start = cyc;
        have_start = 1'b1;
        exp_id     = 1;
      end else if (op_valid) begin
        chk("id_seq", 64'(voice_op), 64'(exp_id));
        exp_id++;
      end
      if (frame_done) begin
        chk("done_valid", 64'(op_valid), 64'd0);
        chk("done_last_id", 64'(exp_id), 64'(N));
        if (have_start) chk("done_after_start", 64'(cyc - last_start), 64'(N));
        last_done = cyc;
        have_done = 1'b1;
      end
      if (ps_we || note_we != 2'b00) begin
        strobe_count++;
        chk("strobe_window", 64'(have_done && (cyc - last_done) >= 1 &&
                                 (cyc - last_done) <= GAP), 64'd1);
        if (op_valid) chk("strobe_trail", 64'(frame_start), 64'd1);
        chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) chk("sb_write", 64'({ps_we, note_we, wr_addr, wr_data}),
                                  64'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    int s0, s1, s2, acc, w, dc, sc0, vcnt;
    rst_n     = 1'b0;
    enable    = 1'b0;
    cmd_valid = 1'b0;
    cmd_type  = 2'd0;
    cmd_addr  = 8'h00;
    cmd_data  = 16'h0000;

    repeat (3) tick();
    chk("reset_outs", 64'(outs_s), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_during_release", 64'(cmd_ready), 64'd0);
    tick();
    chk("ready_after_rst", 64'(cmd_ready), 64'd1);
    chk("idle_valid", 64'(op_valid), 64'd0);

    // Commit ordering: three commands queued while idle
    push(2'd0, 8'h2A, 16'h1234, acc, w);
    push(2'd1, 8'h55, 16'hFFFF, acc, w);
    push(2'd2, 8'h66, 16'h0001, acc, w);
    repeat (20) tick();
    chk("idle_no_drain", 64'(strobe_count), 64'd0);
    chk("ready_not_full", 64'(cmd_ready), 64'd1);
    enable = 1'b1;
    dc = cyc;
    wait_start(s0);
    chk("start_latency", 64'(s0 - dc), 64'd1);
    wait_start(s1);
    chk("frame_period1", 64'(s1 - s0), 64'(N + GAP));
    wait_start(s2);
    chk("frame_period2", 64'(s2 - s1), 64'(N + GAP));
    chk("drain3_count", 64'(strobe_count), 64'd3);
    chk("drain3_sb", 64'(sb_q.size()), 64'd0);

    // Back-pressure: five pushes during a sweep into a depth-4 FIFO
    for (int i = 0; i < 4; i++) begin
      push(2'd0, 8'(i * 16 + 3), 16'(16'hA000 + i), acc, w);
      chk("fill_no_stall", 64'(w), 64'd0);
    end
    push(2'd0, 8'hF7, 16'hA004, acc, w);
    chk("fifth_stalled", 64'(w > 200), 64'd1);
    chk("stall_release", 64'(acc - last_done), 64'd1);

    // Enable dropped mid-sweep
    wait_id(100);
    enable = 1'b0;
    chk("sb_after_burst", 64'(sb_q.size()), 64'd0);
    wait_done(dc);
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (op_valid || frame_start) vcnt++;
    end
    chk("idle_after_disable", 64'(vcnt), 64'd0);
    chk("burst_strobes", 64'(strobe_count), 64'd8);

    // Type-3 commands are consumed silently
    push(2'd3, 8'h11, 16'h1111, acc, w);
    push(2'd1, 8'h22, 16'h5555, acc, w);
    push(2'd3, 8'h33, 16'h3333, acc, w);
    push(2'd0, 8'h77, 16'hBEEF, acc, w);
    chk("full_idle", 64'(cmd_ready), 64'd0);
    sc0 = strobe_count;
    enable = 1'b1;
    wait_start(s0);
    enable = 1'b0;
    wait_done(dc);
    repeat (GAP + 2) tick();
    chk("type3_drained", 64'(cmd_ready), 64'd1);
    chk("type3_strobes", 64'(strobe_count - sc0), 64'd2);
    chk("type3_sb", 64'(sb_q.size()), 64'd0);

    // Reset in the middle of a sweep with commands pending
    push(2'd0, 8'h01, 16'h0101, acc, w);
    push(2'd1, 8'h02, 16'h0202, acc, w);
    push(2'd2, 8'h03, 16'h0303, acc, w);
    enable = 1'b1;
    wait_start(s0);
    wait_id(50);
    rst_n = 1'b0;
    #1;
    chk("reset_async", 64'(outs_s), 64'd0);
    sb_q.delete();
    enable = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst2", 64'(cmd_ready), 64'd1);
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (op_valid) vcnt++;
    end
    chk("idle_after_reset", 64'(vcnt), 64'd0);
    sc0 = strobe_count;
    enable = 1'b1;
    wait_start(s0);
    enable = 1'b0;
    wait_done(dc);
    repeat (GAP + 4) tick();
    chk("no_strobe_after_reset", 64'(strobe_count - sc0), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
